// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register: hold/shift/rotate/arith/load/clear, one bit per clock,
// valid/ready command handshake with done pulse. Define SHREG_OVF_EN to add the sticky ovf output.
module univ_shift_reg_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             CLRb,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             SDR,
  input  logic             SDL,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             done
`ifdef SHREG_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_step;
  logic [2:0]       w_step_mode;

  // Modes that consume amount and advance one bit per edge.
  function automatic logic f_is_step(input logic [2:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

  function automatic logic [WIDTH-1:0] f_step(input logic [2:0]       m,
                                               input logic [WIDTH-1:0] q,
                                               input logic             sdr,
                                               input logic             sdl);
    logic [WIDTH-1:0] res;
    case (m)
      MODE_SHR: res = {sdr, q[WIDTH-1:1]};
      MODE_SHL: res = {q[WIDTH-2:0], sdl};
      MODE_ROR: res = {q[0], q[WIDTH-1:1]};
      MODE_ROL: res = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR: res = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  res = q;
    endcase
    return res;
  endfunction

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign Q         = r_q;
  assign SOR       = r_q[0];
  assign SOL       = r_q[WIDTH-1];
  assign done      = r_done;

  always_ff @(posedge clk or negedge CLRb) begin
    if (!CLRb) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Accept edge executes the first step itself; RUN covers the remaining amount-1 steps.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    w_step      = 1'b0;
    w_step_mode = r_mode;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_mode_nxt  = mode;
          w_step_mode = mode;
          if (f_is_step(mode)) begin
            if (amount == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_step = 1'b1;
              if (amount == CNT_W'(1)) begin
                w_done_nxt = 1'b1;
              end else begin
                w_cnt_nxt   = CNT_W'(amount - CNT_W'(1));
                w_state_nxt = S_RUN;
              end
            end
          end else begin
            w_done_nxt = 1'b1;
            if (mode == MODE_LOAD) begin
              w_q_nxt = D;
            end else if (mode == MODE_CLR) begin
              w_q_nxt = '0;
            end
          end
        end
      end
      S_RUN: begin
        w_step    = 1'b1;
        w_cnt_nxt = CNT_W'(r_cnt - CNT_W'(1));
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    endcase
    if (w_step) begin
      w_q_nxt = f_step(w_step_mode, r_q, SDR, SDL);
    end
  end

`ifdef SHREG_OVF_EN
  logic r_ovf;
  logic w_ovf_nxt;

  // Bit lost off the end of the register for the non-circular shifts.
  function automatic logic f_spill(input logic [2:0] m, input logic [WIDTH-1:0] q);
    logic res;
    case (m)
      MODE_SHL:           res = q[WIDTH-1];
      MODE_SHR, MODE_ASR: res = q[0];
      default:            res = 1'b0;
    endcase
    return res;
  endfunction

  assign ovf = r_ovf;

  // Cleared by any accept, but a spill on that same edge wins.
  always_comb begin
    w_ovf_nxt = r_ovf;
    if (w_accept) begin
      w_ovf_nxt = 1'b0;
    end
    if (w_step && f_spill(w_step_mode, r_q)) begin
      w_ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge CLRb) begin
    if (!CLRb) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n (WIDTH=8); checks ovf too when SHREG_OVF_EN is defined.
module tb_univ_shift_reg_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             CLRb;
  logic [WIDTH-1:0] D;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             SDR;
  logic             SDL;
  logic [WIDTH-1:0] Q;
  logic             SOR;
  logic             SOL;
  logic             done;
`ifdef SHREG_OVF_EN
  logic             ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  univ_shift_reg_n #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .CLRb      (CLRb),
    .D         (D),
    .mode      (mode),
    .amount    (amount),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .SDR       (SDR),
    .SDL       (SDL),
    .Q         (Q),
    .SOR       (SOR),
    .SOL       (SOL),
    .done      (done)
`ifdef SHREG_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one command for exactly one edge (caller knows the block is idle).
  task automatic issue(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] d);
    mode      = m;
    amount    = amt;
    D         = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    CLRb      = 1'b0;
    D         = 8'($urandom);
    mode      = 3'($urandom);
    amount    = 4'($urandom);
    cmd_valid = 1'($urandom);
    SDR       = 1'($urandom);
    SDL       = 1'($urandom);
    repeat (2) @(negedge clk);
    check("rst_q", Q, 8'h00);
    check("rst_done", 8'(done), 8'd0);
    check("rst_ready", 8'(cmd_ready), 8'd1);
`ifdef SHREG_OVF_EN
    check("rst_ovf", 8'(ovf), 8'd0);
`endif
    cmd_valid = 1'b0;
    CLRb      = 1'b1;
    repeat (5) tick();
    check("idle_q", Q, 8'h00);
    check("idle_done", 8'(done), 8'd0);

    // Load A5, then rotate left 3 with cmd_valid toggled high during RUN.
    issue(3'b011, 4'd0, 8'hA5);
    check("load_q", Q, 8'hA5);
    check("load_done", 8'(done), 8'd1);
    issue(3'b101, 4'd3, 8'h00);
    check("rol1_q", Q, 8'h4B);
    check("rol1_ready", 8'(cmd_ready), 8'd0);
    check("rol1_done", 8'(done), 8'd0);
    mode      = 3'b011;
    D         = 8'h00;
    cmd_valid = 1'b1;
    tick();
    check("rol2_q", Q, 8'h96);
    check("rol2_ready", 8'(cmd_ready), 8'd0);
    check("rol2_done", 8'(done), 8'd0);
    tick();
    cmd_valid = 1'b0;
    check("rol3_q", Q, 8'h2D);
    check("rol3_done", 8'(done), 8'd1);
    check("rol3_ready", 8'(cmd_ready), 8'd1);

    // Back-to-back: load 96 in the done cycle, then ASR 4 in the next done cycle.
    issue(3'b011, 4'd0, 8'h96);
    check("b2b_q", Q, 8'h96);
    check("b2b_done", 8'(done), 8'd1);
    issue(3'b110, 4'd4, 8'h00);
    check("asr1_q", Q, 8'hCB);
    check("asr1_sor", 8'(SOR), 8'd1);
    check("asr1_sol", 8'(SOL), 8'd1);
    check("asr1_done", 8'(done), 8'd0);
    tick();
    check("asr2_q", Q, 8'hE5);
    check("asr2_sor", 8'(SOR), 8'd1);
    tick();
    check("asr3_q", Q, 8'hF2);
    check("asr3_sor", 8'(SOR), 8'd0);
    check("asr3_sol", 8'(SOL), 8'd1);
    tick();
    check("asr4_q", Q, 8'hF9);
    check("asr4_sor", 8'(SOR), 8'd1);
    check("asr4_done", 8'(done), 8'd1);
`ifdef SHREG_OVF_EN
    check("asr_ovf", 8'(ovf), 8'd1);
`endif
    tick();
    check("asr_done_drop", 8'(done), 8'd0);

    // Serial fill right with SDR=1 from zero.
    issue(3'b111, 4'd0, 8'h00);
    check("clr_q", Q, 8'h00);
`ifdef SHREG_OVF_EN
    check("clr_ovf", 8'(ovf), 8'd0);
`endif
    SDR = 1'b1;
    issue(3'b001, 4'd2, 8'h00);
    check("shr1_q", Q, 8'h80);
    tick();
    check("shr2_q", Q, 8'hC0);
    check("shr2_done", 8'(done), 8'd1);

    // Shift left 8 from FF with SDL=0 empties the register.
    issue(3'b011, 4'd0, 8'hFF);
    SDL = 1'b0;
    issue(3'b010, 4'd8, 8'h00);
    check("shl1_q", Q, 8'hFE);
    check("shl1_ready", 8'(cmd_ready), 8'd0);
    repeat (6) tick();
    check("shl7_done", 8'(done), 8'd0);
    tick();
    check("shl8_q", Q, 8'h00);
    check("shl8_done", 8'(done), 8'd1);
    repeat (3) tick();
`ifdef SHREG_OVF_EN
    check("shl_ovf_sticky", 8'(ovf), 8'd1);
`endif

    // amount=0 on a step mode: no change, done next cycle.
    issue(3'b011, 4'd0, 8'h3C);
`ifdef SHREG_OVF_EN
    check("load_ovf_clr", 8'(ovf), 8'd0);
`endif
    issue(3'b001, 4'd0, 8'h00);
    check("amt0_q", Q, 8'h3C);
    check("amt0_done", 8'(done), 8'd1);
    check("amt0_ready", 8'(cmd_ready), 8'd1);

    // amount > WIDTH: rotate right by 9 equals rotate right by 1.
    issue(3'b100, 4'd9, 8'h00);
    repeat (7) tick();
    check("ror9_pre_done", 8'(done), 8'd0);
    tick();
    check("ror9_q", Q, 8'h1E);
    check("ror9_done", 8'(done), 8'd1);

    // Reset mid-run aborts with no done pulse.
    issue(3'b100, 4'd7, 8'h00);
    tick();
    tick();
    check("abort_pre_q", Q, 8'hC3);
    CLRb = 1'b0;
    #1;
    check("abort_q", Q, 8'h00);
    check("abort_done", 8'(done), 8'd0);
    check("abort_ready", 8'(cmd_ready), 8'd1);
    @(negedge clk);
    CLRb = 1'b1;
    tick();
    check("post_done", 8'(done), 8'd0);
    check("post_ready", 8'(cmd_ready), 8'd1);
    tick();
    check("post_q", Q, 8'h00);
    check("post_done2", 8'(done), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
Parametrised successor to the team's 4-bit universal shift register. It has WIDTH bits, an 8-mode command set (hold/shift/rotate/arithmetic/load/clear) and multi-bit shifts executed one bit per clock. A valid/ready command handshake and a done pulse let a controller FSM sequence it, and serial taps allow cascading. It sits in the datapath between parallel-load sources and serial consumers.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, $clog2(WIDTH+1), width of shift-amount field (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
CLRb  input  1  asynchronous active-low reset
D  input  WIDTH  parallel load data, sampled on load accept
mode  input  3  command opcode, sampled on accept
amount  input  CNT_W  number of single-bit steps for shift/rotate modes
cmd_valid  input  1  command present
cmd_ready  output  1  block idle, command accepted when cmd_valid&cmd_ready
SDR  input  1  serial in for right shift (enters MSB), sampled every step
SDL  input  1  serial in for left shift (enters LSB), sampled every step
Q  output  WIDTH  register contents
SOR  output  1  serial out, right end (= Q[0], combinational)
SOL  output  1  serial out, left end (= Q[WIDTH-1], combinational)
done  output  1  one-cycle completion pulse

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on CLRb. While CLRb=0: Q=0, state=IDLE, step counter=0, done=0; cmd_ready=1 because it is decoded from IDLE.
- Modes: 000 hold; 001 shift right, Q<={SDR,Q[W-1:1]}; 010 shift left, Q<={Q[W-2:0],SDL}; 011 parallel load, Q<=D; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB replicated); 111 clear (Q<=0).
- States: IDLE, RUN. cmd_ready = (state==IDLE). No command queuing. cmd_valid is ignored when not ready.
- Single-cycle modes (000, 011, 111): on the accept edge apply the op and set done=1. State stays IDLE. amount is ignored.
- Step modes (001, 010, 100, 101, 110):
  - amount=0: on the accept edge Q is unchanged, done=1, state stays IDLE.
  - amount=1: on the accept edge apply 1 step, done=1, state stays IDLE.
  - amount>=2: on the accept edge apply 1 step, cnt<=amount-1, go to RUN.
- RUN: each edge applies 1 step using the latched mode and live SDL/SDR, then cnt<=cnt-1. On the edge where cnt==1, return to IDLE and set done=1.
- Latency: an N-step command occupies N edges starting at the accept edge. cmd_ready is low for N-1 cycles.
- done is registered and high for exactly the cycle after the final-step edge. Q and done update on the same edge.
- A new command may be accepted in the same cycle that done is high.
- amount > WIDTH is legal and executed literally: rotate wraps; shift fills entirely with serial-in or sign.
- D and mode are used only at accept. Changes to D/mode/amount during RUN have no effect.
- CLRb asserted mid-RUN aborts immediately: Q=0, no done pulse, IDLE after release.

Optional Feature:
SHREG_OVF_EN: adds output ovf (1 bit, reset 0), a sticky overflow flag.
- ovf is set when any step of mode 010 shifts a 1 out of Q[WIDTH-1].
- ovf is set when any step of mode 110 or 001 shifts a 1 out of Q[0].
- ovf is cleared on the edge that accepts any new command; a 1 shifted out on that same edge still sets it.
- Without the macro: no ovf port and no overflow logic.

Test Plan:
- Reset (WIDTH=8): CLRb=0 with random inputs -> Q=0x00, done=0, cmd_ready=1; hold CLRb=1 and cmd_valid=0 for 5 cycles -> Q stays 0x00.
- Load then rotate: load D=0xA5 -> Q=0xA5 and done pulse after 1 edge; then mode 101, amount=3 -> Q goes 0x4B, 0x96, 0x2D; cmd_ready low 2 cycles; single done pulse.
- Arithmetic shift: from Q=0x96, mode 110, amount=4 -> Q=0xF9 after 4 edges; SOR/SOL track Q[0]/Q[7] each cycle.
- Serial fill: Q=0x00, SDR=1, mode 001, amount=2 -> Q=0xC0. Then Q=0xFF, SDL=0, mode 010, amount=8 -> Q=0x00; with SHREG_OVF_EN, ovf=1 until the next accept.
- Edge cases: mode 001, amount=0 -> Q unchanged, done next cycle. Back-to-back accept in the done cycle is accepted. Toggling cmd_valid during RUN is ignored.
- Reset mid-run: mode 100, amount=7, CLRb low after 3 edges -> Q=0x00 immediately, no done pulse, cmd_ready=1 after release.
